// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the miniRISC PC sequencer.
// Imported by the sequencer top and the branch label extender.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
    FAULT = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          LBL0_MSB = 25;
  localparam int          LBL1_MSB = 20;

  function automatic logic misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sign_extend_branch.sv
// Branch label sign extender: 26-bit pseudo-direct or 21-bit
// PC-relative label, selected by lbl_sel, widened to 32 bits.
module sign_extend_branch
  import pc_seq_pkg::*;
(
  input  logic [LBL0_MSB:0] lbl0_i,
  input  logic [LBL1_MSB:0] lbl1_i,
  input  logic              sel_i,
  output logic [31:0]       ext_o
);

  localparam int PAD0 = 32 - (LBL0_MSB + 1);
  localparam int PAD1 = 32 - (LBL1_MSB + 1);

  logic [31:0] ext0;
  logic [31:0] ext1;

  assign ext0 = {{PAD0{lbl0_i[LBL0_MSB]}}, lbl0_i};
  assign ext1 = {{PAD1{lbl1_i[LBL1_MSB]}}, lbl1_i};

  assign ext_o = sel_i ? ext1 : ext0;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch, issue, wait for execute,
// then select the next PC and trap misaligned targets.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic        lbl_sel,
  input  logic        jr_sel,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        halted,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] lbl_ext;
  logic [31:0] pc_seq;
  logic [31:0] pc_next;

  sign_extend_branch u_sext (
    .lbl0_i (instr_q[LBL0_MSB:0]),
    .lbl1_i (instr_q[LBL1_MSB:0]),
    .sel_i  (lbl_sel),
    .ext_o  (lbl_ext)
  );

  assign pc_seq = pc_q + PC_STEP;

  // jr only redirects when the branch is actually taken
  always_comb begin
    pc_next = pc_seq;
    if (br_taken) begin
      if (jr_sel)       pc_next = jr_target;
      else if (!lbl_sel) pc_next = lbl_ext;
      else              pc_next = pc_seq + lbl_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = EXEC;
      EXEC: begin
        if (exec_done) begin
          if (misaligned(pc_next)) begin
            state_d = FAULT;
          end else begin
            pc_d    = pc_next;
            state_d = halt ? HALT : FETCH;
          end
        end
      end
      FAULT: state_d = FAULT;
      HALT:  state_d = HALT;
      default: state_d = FAULT;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch handshake, next-PC
// selection, wrap, halt, fault and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        exec_done = 1'b0;
  logic        br_taken = 1'b0;
  logic        lbl_sel = 1'b0;
  logic        jr_sel = 1'b0;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic        fault;

  int n_chk = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .exec_done   (exec_done),
    .br_taken    (br_taken),
    .lbl_sel     (lbl_sel),
    .jr_sel      (jr_sel),
    .jr_target   (jr_target),
    .halt        (halt),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs();
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fetch(
    input int          dly,
    input logic [31:0] addr,
    input logic [31:0] word
  );
    check("f_req", {31'b0, imem_req}, 32'd1);
    check("f_addr", imem_addr, addr);
    repeat (dly) begin
      @(posedge clk); #1;
      check("f_addr_hold", imem_addr, addr);
      check("f_valid_wait", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("i_valid", {31'b0, instr_valid}, 32'd1);
    check("i_instr", instr, word);
    check("i_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("e_valid_off", {31'b0, instr_valid}, 32'd0);
    check("e_instr_hold", instr, word);
  endtask

  task automatic exec(
    input int          dly,
    input logic        br,
    input logic        lbl,
    input logic        jr,
    input logic [31:0] tgt,
    input logic        hlt
  );
    imem_ack = 1'b1;
    repeat (dly) begin
      @(posedge clk); #1;
      check("e_ack_ignored", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    br_taken  = br;
    lbl_sel   = lbl;
    jr_sel    = jr;
    jr_target = tgt;
    halt      = hlt;
    @(posedge clk); #1;
    exec_done = 1'b0;
    br_taken  = 1'b0;
    lbl_sel   = 1'b0;
    jr_sel    = 1'b0;
    jr_target = '0;
    halt      = 1'b0;
  endtask

  initial begin
    do_reset();

    // sequential step after a delayed ack
    fetch(2, 32'h0, 32'h0000_0000);
    exec(1, 0, 0, 0, '0, 0);
    check("seq_pc", pc, 32'h4);

    // pseudo-direct to 0x100
    fetch(0, 32'h4, 32'h0000_0100);
    exec(0, 1, 0, 0, '0, 0);
    check("pd_pc", pc, 32'h100);

    // pc-relative -8 from 0x100
    fetch(0, 32'h100, 32'h001F_FFF8);
    exec(0, 1, 1, 0, '0, 0);
    check("rel_pc", pc, 32'hFC);

    fetch(0, 32'hFC, 32'h0000_0400);
    exec(0, 1, 0, 0, '0, 0);
    check("pd400_pc", pc, 32'h400);

    fetch(0, 32'h400, 32'h03FF_FFF0);
    exec(0, 1, 0, 0, '0, 0);
    check("pdneg_pc", pc, 32'hFFFF_FFF0);

    // jr/lbl ignored when not taken
    fetch(0, 32'hFFFF_FFF0, 32'h0000_0000);
    exec(0, 0, 1, 1, 32'h2000, 0);
    check("nt_pc", pc, 32'hFFFF_FFF4);

    fetch(0, 32'hFFFF_FFF4, 32'h0000_0010);
    exec(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
    check("jr_pc", pc, 32'hFFFF_FFFC);

    fetch(0, 32'hFFFF_FFFC, 32'h0000_0000);
    exec(0, 0, 0, 0, '0, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_fault", {31'b0, fault}, 32'd0);

    fetch(0, 32'h0, 32'h0000_0000);
    exec(0, 0, 0, 0, '0, 1);
    check("halt_pc", pc, 32'h4);
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_req", {31'b0, imem_req}, 32'd0);
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    check("halt_stay", {31'b0, halted}, 32'd1);
    check("halt_pc_stay", pc, 32'h4);
    check("halt_req_stay", {31'b0, imem_req}, 32'd0);

    // reset mid-EXEC
    do_reset();
    fetch(0, 32'h0, 32'h0000_0000);
    exec(0, 0, 0, 0, '0, 0);
    fetch(0, 32'h4, 32'hDEAD_BEEC);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(0, 32'h0, 32'h0000_0000);
    exec(0, 0, 0, 0, '0, 0);
    check("post_rst_pc", pc, 32'h4);

    // reset mid-FETCH
    check("mf_addr", imem_addr, 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(1, 32'h0, 32'h0000_0000);

    // misaligned jr
    exec(0, 1, 0, 1, 32'h2002, 0);
    check("flt_flag", {31'b0, fault}, 32'd1);
    check("flt_pc", pc, 32'h0);
    check("flt_req", {31'b0, imem_req}, 32'd0);
    check("flt_halted", {31'b0, halted}, 32'd0);
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("flt_stay", {31'b0, fault}, 32'd1);
    check("flt_req_stay", {31'b0, imem_req}, 32'd0);

    // fault wins over halt
    do_reset();
    fetch(0, 32'h0, 32'h0000_0000);
    exec(0, 1, 0, 1, 32'h2002, 1);
    check("fh_fault", {31'b0, fault}, 32'd1);
    check("fh_halted", {31'b0, halted}, 32'd0);
    check("fh_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the miniRISC core. It owns the PC register, fetches instructions through a request/acknowledge handshake, issues each instruction to decode, and waits for the datapath to finish. It then computes the next PC from sequential, pseudo-direct, PC-relative or register-indirect targets. It sits between instruction memory and the decode/execute datapath and is the sole writer of the PC.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  fetch address (equals current PC)
- imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  one-cycle pulse: instr holds a new instruction
- instr  out  32  latched instruction, stable from ISSUE until the next fetch completes
- pc  out  32  current PC
- exec_done  in  1  datapath finished the issued instruction
- br_taken  in  1  branch/jump taken; sampled with exec_done
- lbl_sel  in  1  0 = pseudo-direct, 1 = PC-relative; sampled with exec_done
- jr_sel  in  1  register-indirect jump; overrides lbl_sel; sampled with exec_done
- jr_target  in  32  register jump target
- halt  in  1  stop after the current instruction; sampled with exec_done
- halted  out  1  sequencer in HALT
- fault  out  1  misaligned next PC detected; sequencer in FAULT

## Operation
- States: FETCH, ISSUE, EXEC, FAULT, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata into instr and go to ISSUE.
- ISSUE: instr_valid=1 for exactly one cycle, then go to EXEC.
- EXEC: wait for exec_done. On exec_done, compute next:
  - jr_sel=1 and br_taken=1: next = jr_target.
  - Otherwise, br_taken=1 and lbl_sel=0: next = sext32(instr[25:0]), an absolute byte address.
  - Otherwise, br_taken=1 and lbl_sel=1: next = pc + 4 + sext32(instr[20:0]).
  - br_taken=0: next = pc + 4. jr_sel and lbl_sel are ignored.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no fault.
- Fault check: if next[1:0] != 0, pc is not updated, the state goes to FAULT, and fault=1.
- Halt: if the fault check passes and halt=1, pc <- next and the state goes to HALT.
- Normal update: if the fault check passes and halt=0, pc <- next and the state goes to FETCH.
- Fault priority: a fault takes priority over halt in the same cycle.
- FAULT and HALT are terminal; only rst exits them.
- imem_ack outside FETCH is ignored. exec_done outside EXEC is ignored.

## Timing
- Reset values: pc=PC_RESET, state=FETCH, imem_req=1 (combinational from state), instr=0, instr_valid=0, halted=0, fault=0.
- Reset is asynchronous. Asserting rst mid-fetch drops any in-flight request and restarts FETCH at PC_RESET after release.
- imem_req, instr_valid, halted and fault are Moore outputs decoded from state.
- Minimum instruction time is 3 cycles: FETCH with immediate ack, then ISSUE, then EXEC with immediate exec_done.
- pc updates on the edge that leaves EXEC. imem_addr shows the new pc in the following FETCH cycle.
- A new fetch never overlaps an unfinished instruction; there is no speculation.

## Structure
- Package pc_seq_pkg:
  - state enum (FETCH, ISSUE, EXEC, FAULT, HALT)
  - PC_STEP = 32'd4
  - LBL0_MSB = 25
  - LBL1_MSB = 20
- Instantiate the team's existing sign_extend_branch unit for both label extensions. Feed it instr[25:0], instr[20:0] and lbl_sel.
- Next-PC mux and fault check are combinational. The FSM and the pc/instr registers form one always block pair.

## Test plan
- Reset, then 2-cycle ack delay: imem_addr=0 until ack. instr_valid pulses once. After exec_done with br_taken=0, the next fetch is at 0x4.
- PC-relative branch: pc=0x100, instr[20:0]=21'h1FFFF8 (-8), br_taken=1, lbl_sel=1. Next fetch at 0xFC.
- Pseudo-direct jump: instr[25:0]=26'h0000400, br_taken=1, lbl_sel=0. Next fetch at 0x400. With 26'h3FFFFF0 the next fetch is at 0xFFFF_FFF0.
- jr with jr_target=0x2002 and br_taken=1: fault=1, pc unchanged, imem_req stays 0. Asserting halt in the same cycle still gives FAULT, not HALT.
- Wrap and halt: pc=0xFFFF_FFFC with sequential completion gives pc=0. Then halt=1 with exec_done gives halted=1, no further imem_req, and pc=4.
- rst asserted mid-FETCH and mid-EXEC: all outputs return to reset values immediately, and the first fetch after release is at PC_RESET.
